alu_wide_sequencer: RTL
=======================

Name: alu_wide_sequencer

Overview:
- Initiator-side controller for the 32-bit combinational ALU.
- Performs multi-word (32*WORDS-bit) add, sub, and, or and slt by driving the ALU one 32-bit word per cycle, least-significant word first.
- Registers the carry between words and assembles the wide result.
- Sits between the datapath issue logic and a single ALU instance; it owns the ALU ctl/a/b/cin inputs and samples its result/carry outputs.

Parameters:
- WORDS, 2, number of 32-bit words per operand (legal range 2..8).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only when accepting (see Behaviour).
- funct  input  6  operation: 32 add, 34 sub, 36 and, 37 or, 42 slt.
- op_a  input  32*WORDS  operand A.
- op_b  input  32*WORDS  operand B.
- busy  output  1  high while words are being issued.
- done  output  1  one-cycle pulse when result is valid.
- err  output  1  valid with done; high if funct is unsupported.
- result  output  32*WORDS  wide result, held until the next accepted start.
- carry_out  output  1  carry out of the top word (add/sub only), held with result.
- alu_ctl  output  6  ALU control.
- alu_a  output  32  ALU input A.
- alu_b  output  32  ALU input B.
- alu_cin  output  1  ALU carry in.
- alu_result  input  32  ALU sum/result, combinational from alu_* outputs.
- alu_carry  input  1  ALU carry out of bit 31.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (async, any state, including mid-RUN):
  - state=IDLE; busy, done, err, carry_out = 0; result = 0.
  - alu_ctl, alu_a, alu_b, alu_cin = 0; word index = 0; carry register = 0.
  - No done is produced for an interrupted operation.
- Accept:
  - start is accepted at a rising edge when state is IDLE or DONE.
  - Accept latches op_a, op_b and funct, clears result, and sets index=0.
  - If funct is supported, go to RUN. Otherwise go directly to DONE with err=1, result=0, carry_out=0.
  - start during RUN is ignored; no queueing.
- RUN, word i (index i = 0..WORDS-1):
  - alu_ctl = latched funct.
  - alu_a = op_a[32i+31:32i]; alu_b = op_b[32i+31:32i].
  - alu_cin for i=0: 1 for sub/slt, 0 otherwise.
  - alu_cin for i>0: the registered alu_carry from word i-1 for add/sub/slt, 0 for and/or.
  - At each edge, result word i <= alu_result, carry register <= alu_carry, index increments.
  - busy = 1 throughout RUN.
- Slt handling:
  - The ALU returns {31'b0, sum[31]} for ctl 42, which is unusable for the inner words.
  - For slt, drive alu_ctl = 34 (sub) on every word.
  - After the last word: result = {(32*WORDS-1) zeros, bit 31 of the top-word difference}. This is the sign of A-B with no overflow correction, matching the 32-bit ALU slt semantics.
- Last word (i=WORDS-1): at its edge, go to DONE and set carry_out:
  - add/sub: alu_carry of the top word.
  - and/or/slt: 0.
- DONE:
  - done=1 and busy=0 for exactly one cycle; err valid.
  - Next state is IDLE, or RUN if start is accepted in this cycle (back-to-back permitted).
  - result, carry_out and err hold until the next accepted start.
- Latency: start accepted at edge 0 → done high in the cycle after edge WORDS (WORDS+1 cycles total). Unsupported funct → done the cycle after edge 0.
- ALU outputs outside RUN: alu_a, alu_b, alu_cin = 0; alu_ctl = 0.
- Sub convention: carry_out=1 means no borrow (A >= B unsigned); carry_out=0 means borrow.

Test Plan:
- WORDS=2, add, A=0x00000000_FFFFFFFF, B=0x1 → result 0x00000001_00000000, carry_out 0, done exactly 3 cycles after the start edge, busy high 2 cycles.
- add, A=0xFFFFFFFF_FFFFFFFF, B=0x1 → result 0, carry_out 1; then sub, A=0, B=1 → result 0xFFFFFFFF_FFFFFFFF, carry_out 0.
- slt, A=0x5, B=0x00000001_00000000 → result 1. Then A=0x00000001_00000000, B=0x5 → result 0. alu_ctl observed as 34 on both words.
- and, A=0xF0F0F0F0_12345678, B=0xFF00FF00_0000FFFF → 0xF000F000_00005678; or, same operands → 0xFFF0FFF0_1234FFFF, carry_out 0.
- start pulsed again during RUN → ignored, first result unchanged. start asserted in the DONE cycle → second operation runs back-to-back with correct result.
- funct=0x27 → done after 1 cycle, err=1, result 0. Reset asserted mid-RUN → all outputs 0 immediately, no done; a subsequent add completes normally.

Source files
------------

// File: rtl/alu_wide_sequencer.sv
// Multi-word ALU sequencer: drives a 32-bit combinational ALU one word per cycle,
// LSW first, chaining the carry and assembling a 32*WORDS-bit result.
//
// state  | meaning
// IDLE   | waiting for start
// RUN    | issuing word idx_q to the ALU, busy high
// DONE   | one-cycle done pulse, result/err/carry_out valid
module alu_wide_sequencer #(
    parameter int WORDS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [5:0]          funct,
    input  logic [32*WORDS-1:0] op_a,
    input  logic [32*WORDS-1:0] op_b,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [32*WORDS-1:0] result,
    output logic                carry_out,
    output logic [5:0]          alu_ctl,
    output logic [31:0]         alu_a,
    output logic [31:0]         alu_b,
    output logic                alu_cin,
    input  logic [31:0]         alu_result,
    input  logic                alu_carry
);

    localparam int W    = 32 * WORDS;
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(WORDS - 1);

    localparam logic [5:0] F_ADD = 6'd32;
    localparam logic [5:0] F_SUB = 6'd34;
    localparam logic [5:0] F_AND = 6'd36;
    localparam logic [5:0] F_OR  = 6'd37;
    localparam logic [5:0] F_SLT = 6'd42;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [5:0]      funct_q;
    logic [W-1:0]    opa_sh_q;
    logic [W-1:0]    opb_sh_q;
    logic [IDXW-1:0] idx_q;
    logic [W-1:0]    result_q;
    logic            carry_out_q;
    logic            err_q;
    logic            busy_q;
    logic            done_q;
    logic [5:0]      alu_ctl_q;
    logic [31:0]     alu_a_q;
    logic [31:0]     alu_b_q;
    logic            alu_cin_q;

    logic            accept;
    logic            supported;
    logic            last_word;
    logic            chained;
    logic            arith_carry;
    logic [W-1:0]    result_d;

    always_comb begin
        accept      = start && (state_q != S_RUN);
        supported   = (funct == F_ADD) || (funct == F_SUB) || (funct == F_AND) ||
                      (funct == F_OR)  || (funct == F_SLT);
        last_word   = (idx_q == IDX_LAST);
        chained     = (funct_q == F_ADD) || (funct_q == F_SUB) || (funct_q == F_SLT);
        arith_carry = (funct_q == F_ADD) || (funct_q == F_SUB);
        result_d    = result_q;
        result_d[{idx_q, 5'b00000} +: 32] = alu_result;
    end

    // alu_cin_q doubles as the inter-word carry register; operands shift down one word per issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            funct_q     <= '0;
            opa_sh_q    <= '0;
            opb_sh_q    <= '0;
            idx_q       <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            alu_ctl_q   <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_cin_q   <= 1'b0;
        end else if (accept) begin
            funct_q     <= funct;
            opa_sh_q    <= op_a >> 32;
            opb_sh_q    <= op_b >> 32;
            idx_q       <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            if (supported) begin
                state_q   <= S_RUN;
                busy_q    <= 1'b1;
                done_q    <= 1'b0;
                err_q     <= 1'b0;
                alu_ctl_q <= (funct == F_SLT) ? F_SUB : funct;
                alu_a_q   <= op_a[31:0];
                alu_b_q   <= op_b[31:0];
                alu_cin_q <= (funct == F_SUB) || (funct == F_SLT);
            end else begin
                state_q   <= S_DONE;
                busy_q    <= 1'b0;
                done_q    <= 1'b1;
                err_q     <= 1'b1;
                alu_ctl_q <= '0;
                alu_a_q   <= '0;
                alu_b_q   <= '0;
                alu_cin_q <= 1'b0;
            end
        end else begin
            case (state_q)
                S_RUN: begin
                    result_q <= result_d;
                    idx_q    <= idx_q + IDXW'(1);
                    if (last_word) begin
                        state_q     <= S_DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        carry_out_q <= arith_carry && alu_carry;
                        alu_ctl_q   <= '0;
                        alu_a_q     <= '0;
                        alu_b_q     <= '0;
                        alu_cin_q   <= 1'b0;
                        // slt keeps only the sign of the top-word difference
                        if (funct_q == F_SLT) begin
                            result_q <= {{(W-1){1'b0}}, alu_result[31]};
                        end
                    end else begin
                        alu_a_q   <= opa_sh_q[31:0];
                        alu_b_q   <= opb_sh_q[31:0];
                        opa_sh_q  <= opa_sh_q >> 32;
                        opb_sh_q  <= opb_sh_q >> 32;
                        alu_cin_q <= chained && alu_carry;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign alu_ctl   = alu_ctl_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_cin   = alu_cin_q;

endmodule
